// File: rtl/lc3_control_fsm_pkg.sv
// Shared definitions for the LC-3 control sequencer: state codes in LC-3
// microsequencer numbering, opcodes, datapath mux encodings and the control word.
package lc3_control_fsm_pkg;

    typedef enum logic [5:0] {
        S_BR     = 6'd0,
        S_ADD    = 6'd1,
        S_LD1    = 6'd2,
        S_ST1    = 6'd3,
        S_AND    = 6'd5,
        S_NOT    = 6'd9,
        S_JMP    = 6'd12,
        S_LEA    = 6'd14,
        S_TRAP1  = 6'd15,
        S_ST3    = 6'd16,
        S_FETCH1 = 6'd18,
        S_BR_T   = 6'd22,
        S_ST2    = 6'd23,
        S_LD2    = 6'd25,
        S_LD3    = 6'd27,
        S_TRAP2  = 6'd28,
        S_TRAP3  = 6'd30,
        S_DECODE = 6'd32,
        S_FETCH2 = 6'd33,
        S_FETCH3 = 6'd35,
        S_HALT   = 6'd62,
        S_IDLE   = 6'd63
    } state_e;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RES  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

    localparam logic [1:0] SR1_IR11_9 = 2'b00;
    localparam logic [1:0] SR1_IR8_6  = 2'b01;
    localparam logic [1:0] SR1_R6     = 2'b10;

    localparam logic [1:0] DR_IR11_9  = 2'b00;
    localparam logic [1:0] DR_R7      = 2'b01;
    localparam logic [1:0] DR_R6      = 2'b10;

    localparam logic [1:0] PC_INC     = 2'b00;
    localparam logic [1:0] PC_BUS     = 2'b01;
    localparam logic [1:0] PC_ADDER   = 2'b10;

    localparam logic       ADDR1_PC   = 1'b0;
    localparam logic       ADDR1_SR1  = 1'b1;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    localparam logic       MARMUX_ZEXT  = 1'b0;
    localparam logic       MARMUX_ADDER = 1'b1;

    typedef struct packed {
        logic       mem_en;
        logic       mem_we;
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_pc;
        logic       ld_reg;
        logic       ld_cc;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic [1:0] aluk;
        logic [1:0] sr1mux;
        logic [1:0] drmux;
        logic [1:0] pcmux;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic       marmux;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    // States that sit on the memory handshake and are watched by the timeout counter.
    function automatic logic is_wait_state(input state_e s);
        return (s == S_FETCH2) || (s == S_LD2) || (s == S_ST3) || (s == S_TRAP2);
    endfunction

    function automatic logic branch_enable(input logic [2:0] nzp_sel,
                                           input logic n, input logic z, input logic p);
        return (nzp_sel[2] & n) | (nzp_sel[1] & z) | (nzp_sel[0] & p);
    endfunction

endpackage

// File: rtl/lc3_control_fsm_mem_timer.sv
// Memory-wait watchdog: counts wait cycles without ready and flags expiry when
// the count has reached MEM_TIMEOUT and ready is still low.
module lc3_control_fsm_mem_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMR_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    input  logic ready,
    output logic expire
);

    localparam logic [TMR_W-1:0] LIMIT = TMR_W'(MEM_TIMEOUT);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !ready && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    // A ready arriving on the limit cycle completes the access instead of faulting.
    assign expire = enable && !ready && (count == LIMIT);

endmodule

// File: rtl/lc3_control_fsm.sv
// LC-3 control microsequencer (Moore). Define LC3_CTRL_TRAP_EN to add the TRAP
// sequence; otherwise TRAP decodes as illegal and halts with a fault.
module lc3_control_fsm
    import lc3_control_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMR_W       = 8
) (
    input  logic        i_CLK,
    input  logic        i_RST_N,
    input  logic [15:0] i_IR,
    input  logic        i_N,
    input  logic        i_Z,
    input  logic        i_P,
    input  logic        i_MEM_R,
    output logic        o_MEM_EN,
    output logic        o_MEM_WE,
    output logic        o_LD_MAR,
    output logic        o_LD_MDR,
    output logic        o_LD_IR,
    output logic        o_LD_PC,
    output logic        o_LD_REG,
    output logic        o_LD_CC,
    output logic        o_GATE_PC,
    output logic        o_GATE_MDR,
    output logic        o_GATE_ALU,
    output logic        o_GATE_MARMUX,
    output logic [1:0]  o_ALUK,
    output logic [1:0]  o_SR1MUX,
    output logic [1:0]  o_DRMUX,
    output logic [1:0]  o_PCMUX,
    output logic        o_ADDR1MUX,
    output logic [1:0]  o_ADDR2MUX,
    output logic        o_MARMUX,
    output logic        o_FAULT,
    output logic [5:0]  o_STATE
);

    // Memory handshake: o_MEM_EN (with o_MEM_WE for writes) is held every cycle of a
    // wait state; the access completes on the first edge where i_MEM_R is sampled high.

    state_e state_q;
    state_e state_d;
    logic   fault_q;
    logic   ben_q;
    logic   in_wait;
    logic   tmr_expire;
    ctrl_t  ctrl;
    logic   ir_unused;

    assign ir_unused = ^i_IR[8:0];
    assign in_wait   = is_wait_state(state_q);

    lc3_control_fsm_mem_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TMR_W       (TMR_W)
    ) u_mem_timer (
        .clk    (i_CLK),
        .rst_n  (i_RST_N),
        .clear  (!in_wait),
        .enable (in_wait),
        .ready  (i_MEM_R),
        .expire (tmr_expire)
    );

    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            state_q <= S_IDLE;
            fault_q <= 1'b0;
            ben_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == S_HALT) begin
                fault_q <= 1'b1;
            end
            if (state_q == S_DECODE) begin
                ben_q <= branch_enable(i_IR[11:9], i_N, i_Z, i_P);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH1;
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: begin
                if (i_MEM_R)         state_d = S_FETCH3;
                else if (tmr_expire) state_d = S_HALT;
            end
            S_FETCH3: state_d = S_DECODE;
            S_DECODE: begin
                case (i_IR[15:12])
                    OP_BR:   state_d = S_BR;
                    OP_ADD:  state_d = S_ADD;
                    OP_AND:  state_d = S_AND;
                    OP_NOT:  state_d = S_NOT;
                    OP_LD:   state_d = S_LD1;
                    OP_ST:   state_d = S_ST1;
                    OP_JMP:  state_d = S_JMP;
                    OP_LEA:  state_d = S_LEA;
`ifdef LC3_CTRL_TRAP_EN
                    OP_TRAP: state_d = S_TRAP1;
`endif
                    // JSR, LDR, STR, LDI, STI, RTI, reserved and disabled TRAP.
                    default: state_d = S_HALT;
                endcase
            end
            S_ADD, S_AND, S_NOT: state_d = S_FETCH1;
            S_LD1: state_d = S_LD2;
            S_LD2: begin
                if (i_MEM_R)         state_d = S_LD3;
                else if (tmr_expire) state_d = S_HALT;
            end
            S_LD3: state_d = S_FETCH1;
            S_ST1: state_d = S_ST2;
            S_ST2: state_d = S_ST3;
            S_ST3: begin
                if (i_MEM_R)         state_d = S_FETCH1;
                else if (tmr_expire) state_d = S_HALT;
            end
            S_BR:   state_d = ben_q ? S_BR_T : S_FETCH1;
            S_BR_T: state_d = S_FETCH1;
            S_JMP:  state_d = S_FETCH1;
            S_LEA:  state_d = S_FETCH1;
`ifdef LC3_CTRL_TRAP_EN
            S_TRAP1: state_d = S_TRAP2;
            S_TRAP2: begin
                if (i_MEM_R)         state_d = S_TRAP3;
                else if (tmr_expire) state_d = S_HALT;
            end
            S_TRAP3: state_d = S_FETCH1;
`endif
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    always_comb begin
        ctrl = CTRL_NONE;
        case (state_q)
            S_FETCH1: begin
                ctrl.gate_pc = 1'b1;
                ctrl.ld_mar  = 1'b1;
                ctrl.pcmux   = PC_INC;
                ctrl.ld_pc   = 1'b1;
            end
            S_FETCH2, S_LD2: begin
                ctrl.mem_en = 1'b1;
                ctrl.ld_mdr = 1'b1;
            end
            S_FETCH3: begin
                ctrl.gate_mdr = 1'b1;
                ctrl.ld_ir    = 1'b1;
            end
            S_ADD, S_AND, S_NOT: begin
                ctrl.sr1mux   = SR1_IR8_6;
                ctrl.drmux    = DR_IR11_9;
                ctrl.aluk     = (state_q == S_ADD) ? ALUK_ADD :
                                (state_q == S_AND) ? ALUK_AND : ALUK_NOT;
                ctrl.gate_alu = 1'b1;
                ctrl.ld_reg   = 1'b1;
                ctrl.ld_cc    = 1'b1;
            end
            S_LD1, S_ST1: begin
                ctrl.addr1mux    = ADDR1_PC;
                ctrl.addr2mux    = ADDR2_OFF9;
                ctrl.marmux      = MARMUX_ADDER;
                ctrl.gate_marmux = 1'b1;
                ctrl.ld_mar      = 1'b1;
            end
            S_LD3: begin
                ctrl.gate_mdr = 1'b1;
                ctrl.drmux    = DR_IR11_9;
                ctrl.ld_reg   = 1'b1;
                ctrl.ld_cc    = 1'b1;
            end
            S_ST2: begin
                ctrl.sr1mux   = SR1_IR11_9;
                ctrl.aluk     = ALUK_PASSA;
                ctrl.gate_alu = 1'b1;
                ctrl.ld_mdr   = 1'b1;
            end
            S_ST3: begin
                ctrl.mem_en = 1'b1;
                ctrl.mem_we = 1'b1;
            end
            S_BR_T: begin
                ctrl.addr1mux = ADDR1_PC;
                ctrl.addr2mux = ADDR2_OFF9;
                ctrl.pcmux    = PC_ADDER;
                ctrl.ld_pc    = 1'b1;
            end
            S_JMP: begin
                ctrl.sr1mux   = SR1_IR8_6;
                ctrl.addr1mux = ADDR1_SR1;
                ctrl.addr2mux = ADDR2_ZERO;
                ctrl.pcmux    = PC_ADDER;
                ctrl.ld_pc    = 1'b1;
            end
            S_LEA: begin
                // Effective address goes straight to the register file; CC is left alone.
                ctrl.addr1mux    = ADDR1_PC;
                ctrl.addr2mux    = ADDR2_OFF9;
                ctrl.marmux      = MARMUX_ADDER;
                ctrl.gate_marmux = 1'b1;
                ctrl.drmux       = DR_IR11_9;
                ctrl.ld_reg      = 1'b1;
            end
`ifdef LC3_CTRL_TRAP_EN
            S_TRAP1: begin
                ctrl.marmux      = MARMUX_ZEXT;
                ctrl.gate_marmux = 1'b1;
                ctrl.ld_mar      = 1'b1;
            end
            S_TRAP2: begin
                ctrl.mem_en  = 1'b1;
                ctrl.ld_mdr  = 1'b1;
                ctrl.gate_pc = 1'b1;
                ctrl.drmux   = DR_R7;
                ctrl.ld_reg  = 1'b1;
            end
            S_TRAP3: begin
                ctrl.gate_mdr = 1'b1;
                ctrl.pcmux    = PC_BUS;
                ctrl.ld_pc    = 1'b1;
            end
`endif
            default: ctrl = CTRL_NONE;
        endcase
    end

    assign o_MEM_EN      = ctrl.mem_en;
    assign o_MEM_WE      = ctrl.mem_we;
    assign o_LD_MAR      = ctrl.ld_mar;
    assign o_LD_MDR      = ctrl.ld_mdr;
    assign o_LD_IR       = ctrl.ld_ir;
    assign o_LD_PC       = ctrl.ld_pc;
    assign o_LD_REG      = ctrl.ld_reg;
    assign o_LD_CC       = ctrl.ld_cc;
    assign o_GATE_PC     = ctrl.gate_pc;
    assign o_GATE_MDR    = ctrl.gate_mdr;
    assign o_GATE_ALU    = ctrl.gate_alu;
    assign o_GATE_MARMUX = ctrl.gate_marmux;
    assign o_ALUK        = ctrl.aluk;
    assign o_SR1MUX      = ctrl.sr1mux;
    assign o_DRMUX       = ctrl.drmux;
    assign o_PCMUX       = ctrl.pcmux;
    assign o_ADDR1MUX    = ctrl.addr1mux;
    assign o_ADDR2MUX    = ctrl.addr2mux;
    assign o_MARMUX      = ctrl.marmux;
    assign o_FAULT       = fault_q;
    assign o_STATE       = state_q;

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Directed bench for lc3_control_fsm: the driver walks instruction sequences and queues
// the expected state/control word per cycle; a negedge monitor pops and compares.
module tb_lc3_control_fsm;

    localparam logic [5:0] T_BR = 6'd0,  T_ADD = 6'd1,  T_LD1 = 6'd2,  T_ST1 = 6'd3;
    localparam logic [5:0] T_AND = 6'd5, T_NOT = 6'd9,  T_JMP = 6'd12, T_LEA = 6'd14;
    localparam logic [5:0] T_TRAP1 = 6'd15, T_ST3 = 6'd16, T_FETCH1 = 6'd18, T_BR_T = 6'd22;
    localparam logic [5:0] T_ST2 = 6'd23, T_LD2 = 6'd25, T_LD3 = 6'd27, T_TRAP2 = 6'd28;
    localparam logic [5:0] T_TRAP3 = 6'd30, T_DECODE = 6'd32, T_FETCH2 = 6'd33, T_FETCH3 = 6'd35;
    localparam logic [5:0] T_HALT = 6'd62, T_IDLE = 6'd63;

    localparam logic [23:0] B_MEM_EN = 24'h800000, B_MEM_WE = 24'h400000;
    localparam logic [23:0] B_LD_MAR = 24'h200000, B_LD_MDR = 24'h100000;
    localparam logic [23:0] B_LD_IR  = 24'h080000, B_LD_PC  = 24'h040000;
    localparam logic [23:0] B_LD_REG = 24'h020000, B_LD_CC  = 24'h010000;
    localparam logic [23:0] B_G_PC   = 24'h008000, B_G_MDR  = 24'h004000;
    localparam logic [23:0] B_G_ALU  = 24'h002000, B_G_MARM = 24'h001000;
    localparam logic [23:0] ALUK_AND = 24'h000400, ALUK_NOT = 24'h000800, ALUK_PASS = 24'h000C00;
    localparam logic [23:0] SR1_IR86 = 24'h000100, DR_R7 = 24'h000040;
    localparam logic [23:0] PC_BUS   = 24'h000010, PC_ADDER = 24'h000020;
    localparam logic [23:0] A1_SR1   = 24'h000008, A2_OFF9 = 24'h000004, MM_ADDER = 24'h000001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ir;
    logic        n, z, p, mem_r;
    logic        mem_en, mem_we, ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc;
    logic        gate_pc, gate_mdr, gate_alu, gate_marmux, addr1mux, marmux, fault;
    logic [1:0]  aluk, sr1mux, drmux, pcmux, addr2mux;
    logic [5:0]  state;
    logic [30:0] got_v;

    logic [30:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    string       cur_test = "reset";

    lc3_control_fsm dut (
        .i_CLK(clk), .i_RST_N(rst_n), .i_IR(ir), .i_N(n), .i_Z(z), .i_P(p), .i_MEM_R(mem_r),
        .o_MEM_EN(mem_en), .o_MEM_WE(mem_we), .o_LD_MAR(ld_mar), .o_LD_MDR(ld_mdr),
        .o_LD_IR(ld_ir), .o_LD_PC(ld_pc), .o_LD_REG(ld_reg), .o_LD_CC(ld_cc),
        .o_GATE_PC(gate_pc), .o_GATE_MDR(gate_mdr), .o_GATE_ALU(gate_alu),
        .o_GATE_MARMUX(gate_marmux), .o_ALUK(aluk), .o_SR1MUX(sr1mux), .o_DRMUX(drmux),
        .o_PCMUX(pcmux), .o_ADDR1MUX(addr1mux), .o_ADDR2MUX(addr2mux), .o_MARMUX(marmux),
        .o_FAULT(fault), .o_STATE(state)
    );

    assign got_v = {state, fault, mem_en, mem_we, ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc,
                    gate_pc, gate_mdr, gate_alu, gate_marmux, aluk, sr1mux, drmux, pcmux,
                    addr1mux, addr2mux, marmux};

    always #5 clk = ~clk;

    // Expected control word for each state, written from the state table.
    function automatic logic [23:0] ctl(input logic [5:0] s);
        logic [23:0] c;
        c = '0;
        case (s)
            T_FETCH1:       c = B_G_PC | B_LD_MAR | B_LD_PC;
            T_FETCH2:       c = B_MEM_EN | B_LD_MDR;
            T_FETCH3:       c = B_G_MDR | B_LD_IR;
            T_ADD:          c = B_G_ALU | B_LD_REG | B_LD_CC | SR1_IR86;
            T_AND:          c = B_G_ALU | B_LD_REG | B_LD_CC | SR1_IR86 | ALUK_AND;
            T_NOT:          c = B_G_ALU | B_LD_REG | B_LD_CC | SR1_IR86 | ALUK_NOT;
            T_LD1, T_ST1:   c = A2_OFF9 | MM_ADDER | B_G_MARM | B_LD_MAR;
            T_LD2:          c = B_MEM_EN | B_LD_MDR;
            T_LD3:          c = B_G_MDR | B_LD_REG | B_LD_CC;
            T_ST2:          c = ALUK_PASS | B_G_ALU | B_LD_MDR;
            T_ST3:          c = B_MEM_EN | B_MEM_WE;
            T_BR_T:         c = A2_OFF9 | PC_ADDER | B_LD_PC;
            T_JMP:          c = SR1_IR86 | A1_SR1 | PC_ADDER | B_LD_PC;
            T_LEA:          c = A2_OFF9 | MM_ADDER | B_G_MARM | B_LD_REG;
            T_TRAP1:        c = B_G_MARM | B_LD_MAR;
            T_TRAP2:        c = B_MEM_EN | B_LD_MDR | B_G_PC | DR_R7 | B_LD_REG;
            T_TRAP3:        c = B_G_MDR | PC_BUS | B_LD_PC;
            default:        c = '0;
        endcase
        return c;
    endfunction

    task automatic step(input logic [5:0] s, input logic f);
        exp_q.push_back({s, f, ctl(s)});
        @(posedge clk);
        #1;
    endtask

    task automatic fetch();
        step(T_FETCH1, 1'b0);
        step(T_FETCH2, 1'b0);
        step(T_FETCH3, 1'b0);
        step(T_DECODE, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        step(T_IDLE, 1'b0);
        rst_n = 1'b1;
        step(T_IDLE, 1'b0);
    endtask

    initial begin : monitor
        logic [30:0] exp_v;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                checks++;
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL %s: got state=%0d fault=%b ctl=%h, expected state=%0d fault=%b ctl=%h",
                             cur_test, got_v[30:25], got_v[24], got_v[23:0],
                             exp_v[30:25], exp_v[24], exp_v[23:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: bench did not reach its summary in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        rst_n = 1'b0; ir = 16'h1642; n = 1'b0; z = 1'b0; p = 1'b0; mem_r = 1'b1;
        do_reset();

        cur_test = "add";  ir = 16'h1642; fetch(); step(T_ADD, 1'b0);
        cur_test = "and";  ir = 16'h5642; fetch(); step(T_AND, 1'b0);
        cur_test = "not";  ir = 16'h967F; fetch(); step(T_NOT, 1'b0);

        cur_test = "brz_taken"; ir = 16'h0405; n = 0; z = 1; p = 0;
        fetch(); step(T_BR, 1'b0); step(T_BR_T, 1'b0);
        cur_test = "brz_not_taken"; n = 1; z = 0; p = 0;
        fetch(); step(T_BR, 1'b0);
        cur_test = "br_nzp000"; ir = 16'h0005; n = 1; z = 1; p = 1;
        fetch(); step(T_BR, 1'b0);
        cur_test = "brp_taken"; ir = 16'h0205; n = 0; z = 0; p = 1;
        fetch(); step(T_BR, 1'b0); step(T_BR_T, 1'b0);

        cur_test = "jmp"; ir = 16'hC1C0; fetch(); step(T_JMP, 1'b0);
        cur_test = "lea"; ir = 16'hE405; fetch(); step(T_LEA, 1'b0);
        cur_test = "ld";  ir = 16'h2405; fetch();
        step(T_LD1, 1'b0); step(T_LD2, 1'b0); step(T_LD3, 1'b0);

        cur_test = "st_wait3"; ir = 16'h3405; fetch(); mem_r = 1'b0;
        step(T_ST1, 1'b0); step(T_ST2, 1'b0);
        step(T_ST3, 1'b0); step(T_ST3, 1'b0); step(T_ST3, 1'b0);
        mem_r = 1'b1; step(T_ST3, 1'b0);

        cur_test = "ready_on_limit"; ir = 16'h1642; mem_r = 1'b0;
        step(T_FETCH1, 1'b0);
        repeat (15) step(T_FETCH2, 1'b0);
        mem_r = 1'b1; step(T_FETCH2, 1'b0);
        step(T_FETCH3, 1'b0); step(T_DECODE, 1'b0); step(T_ADD, 1'b0);

        cur_test = "reset_in_ld2"; ir = 16'h2405; fetch(); step(T_LD1, 1'b0); mem_r = 1'b0;
        step(T_LD2, 1'b0); step(T_LD2, 1'b0);
        rst_n = 1'b0; step(T_LD2, 1'b0);
        rst_n = 1'b1; step(T_IDLE, 1'b0);
        mem_r = 1'b1; step(T_FETCH1, 1'b0); step(T_FETCH2, 1'b0); step(T_FETCH3, 1'b0);
        step(T_DECODE, 1'b0); step(T_LD1, 1'b0);

        cur_test = "ld_after_reset"; step(T_LD2, 1'b0); step(T_LD3, 1'b0);

        cur_test = "trap"; ir = 16'hF025; fetch();
`ifdef LC3_CTRL_TRAP_EN
        step(T_TRAP1, 1'b0); step(T_TRAP2, 1'b0); step(T_TRAP3, 1'b0);
`else
        step(T_HALT, 1'b1); step(T_HALT, 1'b1);
        do_reset();
`endif

        cur_test = "reserved_op"; ir = 16'hD000; fetch();
        step(T_HALT, 1'b1); step(T_HALT, 1'b1);
        cur_test = "fault_cleared"; do_reset();
        cur_test = "rti_op"; ir = 16'h8000; fetch();
        step(T_HALT, 1'b1);
        do_reset();

        cur_test = "fetch_timeout"; ir = 16'h1642; mem_r = 1'b0;
        step(T_FETCH1, 1'b0);
        repeat (16) step(T_FETCH2, 1'b0);
        mem_r = 1'b1;
        step(T_HALT, 1'b1); step(T_HALT, 1'b1); step(T_HALT, 1'b1);
        cur_test = "timeout_reset"; do_reset();
        step(T_FETCH1, 1'b0);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
